// File: rtl/modexp_pixel_sequencer_pkg.sv
// Shared types and constants for the modexp pixel sequencer.
// Optional watchdog: define MODEXP_TIMEOUT_EN to enable the ME_WAIT timeout.
package modexp_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_ME_START,
    S_ME_WAIT,
    S_WR,
    S_DONE
  } seq_state_t;

  // Byte distance between consecutive 32-bit pixel words.
  localparam int ADDR_STEP = 4;

  // Bit position of the pixel inside a memory word.
  localparam int PIX_LSB = 0;

endpackage

// File: rtl/modexp_pixel_sequencer_if.sv
// Memory and modexp-unit bus seen by the pixel sequencer.
// master = sequencer side, slave = memory / modexp side.
interface modexp_pixel_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16
);

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic [DATA_W-1:0] me_M;
  logic              me_start;
  logic              me_finished;
  logic [DATA_W-1:0] me_result;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata, me_M, me_start,
    input  mem_rdata, me_finished, me_result
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata, me_M, me_start,
    output mem_rdata, me_finished, me_result
  );

endinterface

// File: rtl/modexp_pixel_sequencer_seq_addr_gen.sv
// Source/destination pointers and completed-pixel counter for the sequencer.
// load restarts a job from the given bases; advance steps to the next pixel.
module seq_addr_gen
  import modexp_seq_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic [ADDR_W-1:0] src_ptr,
  output logic [ADDR_W-1:0] dst_ptr,
  output logic [CNT_W-1:0]  pix_done
);

  logic [ADDR_W-1:0] src_ptr_reg;
  logic [ADDR_W-1:0] dst_ptr_reg;
  logic [CNT_W-1:0]  pix_done_reg;

  // Pointer/counter update; pointers wrap naturally modulo 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_ptr_reg  <= '0;
      dst_ptr_reg  <= '0;
      pix_done_reg <= '0;
    end else if (load) begin
      src_ptr_reg  <= src_base;
      dst_ptr_reg  <= dst_base;
      pix_done_reg <= '0;
    end else if (advance) begin
      src_ptr_reg  <= src_ptr_reg + ADDR_W'(ADDR_STEP);
      dst_ptr_reg  <= dst_ptr_reg + ADDR_W'(ADDR_STEP);
      pix_done_reg <= pix_done_reg + CNT_W'(1);
    end
  end

  assign src_ptr  = src_ptr_reg;
  assign dst_ptr  = dst_ptr_reg;
  assign pix_done = pix_done_reg;

endmodule

// File: rtl/modexp_pixel_sequencer.sv
// Streams encrypted pixels from memory through the modexp unit and writes
// the results back. Optional macro MODEXP_TIMEOUT_EN adds an ME_WAIT
// watchdog that raises a sticky error after TIMEOUT_CYC cycles.
module modexp_pixel_sequencer
  import modexp_seq_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 16,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [CNT_W-1:0]  pix_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  pix_done,
  modexp_pixel_sequencer_if.master bus
);

  seq_state_t        state_reg;
  seq_state_t        state_next;
  logic [CNT_W-1:0]  count_reg;
  logic [DATA_W-1:0] me_m_reg;
  logic [DATA_W-1:0] result_reg;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic              accept;
  logic              last_pix;
  logic              timeout_hit;
  logic              unused_rdata_hi;

  // Only the low pixel bits of a memory word carry data.
  assign unused_rdata_hi = ^bus.mem_rdata[31:DATA_W];

  assign accept   = (state_reg == S_IDLE) && start && (pix_count != '0);
  assign last_pix = (pix_done + CNT_W'(1)) == count_reg;

  seq_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .advance  (state_reg == S_WR),
    .src_base (src_base),
    .dst_base (dst_base),
    .src_ptr  (src_ptr),
    .dst_ptr  (dst_ptr),
    .pix_done (pix_done)
  );

`ifdef MODEXP_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wait_cnt_reg;
  logic            error_reg;

  // The last permitted ME_WAIT cycle is the one where the count reaches
  // TIMEOUT_CYC-1; finished in that same cycle still wins.
  assign timeout_hit = (state_reg == S_ME_WAIT) && !bus.me_finished &&
                       (wait_cnt_reg == WD_W'(TIMEOUT_CYC - 1));

  // Watchdog counter: cleared on the way into ME_WAIT, counts ME_WAIT cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == S_ME_START) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == S_ME_WAIT) begin
      wait_cnt_reg <= wait_cnt_reg + WD_W'(1);
    end
  end

  // Sticky error: set on timeout, cleared only by the next accepted job.
  always_ff @(posedge clk) begin
    if (reset) begin
      error_reg <= 1'b0;
    end else if (accept) begin
      error_reg <= 1'b0;
    end else if (timeout_hit) begin
      error_reg <= 1'b1;
    end
  end

  assign error = error_reg;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign timeout_hit        = 1'b0;
  assign error              = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = (pix_count != '0) ? S_RD_REQ : S_DONE;
        end
      end
      S_RD_REQ:   state_next = S_RD_WAIT;
      S_RD_WAIT:  state_next = S_ME_START;
      S_ME_START: state_next = S_ME_WAIT;
      S_ME_WAIT: begin
        if (bus.me_finished) begin
          state_next = S_WR;
        end else if (timeout_hit) begin
          state_next = S_DONE;
        end
      end
      S_WR:    state_next = last_pix ? S_DONE : S_RD_REQ;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode; address and write data are zero outside their access cycle.
  always_comb begin
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.me_start  = 1'b0;
    done          = 1'b0;
    busy          = (state_reg != S_IDLE) && (state_reg != S_DONE);
    case (state_reg)
      S_RD_REQ: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = src_ptr;
      end
      S_ME_START: bus.me_start = 1'b1;
      S_WR: begin
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = dst_ptr;
        bus.mem_wdata = {{(32 - DATA_W){1'b0}}, result_reg};
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign bus.me_M = me_m_reg;

  // Job length, operand and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg  <= '0;
      me_m_reg   <= '0;
      result_reg <= '0;
    end else begin
      if (accept) begin
        count_reg <= pix_count;
      end
      if (state_reg == S_RD_WAIT) begin
        me_m_reg <= bus.mem_rdata[PIX_LSB +: DATA_W];
      end
      if ((state_reg == S_ME_WAIT) && bus.me_finished) begin
        result_reg <= bus.me_result;
      end
    end
  end

endmodule
